// File: rtl/dds_pkg.sv
// Shared encodings and constants for the DDS waveform generator, plus the
// elaboration-time generator for the quarter-wave sine table.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE = 2'd0,
    WAVE_TRI  = 2'd1,
    WAVE_SAW  = 2'd2,
    WAVE_SQR  = 2'd3
  } wave_e;

  localparam int          DAC_W     = 12;
  localparam logic [11:0] MIDSCALE  = 12'd2048;
  localparam logic [4:0]  AMP_UNITY = 5'd16;

  // round(2047*sin(pi/2*(idx+0.5)/2^aw)) in Q30 fixed point (Taylor series to x^15).
  function automatic logic [10:0] sine_quarter(input int idx, input int aw);
    longint one;
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint den;
    longint val;
    one  = 64'sd1 << 30;
    x    = (64'sd1686629713 * longint'(2 * idx + 1)) / (64'sd1 << (aw + 1));
    x2   = (x * x) / one;
    term = x;
    acc  = x;
    for (int k = 1; k <= 7; k++) begin
      den  = longint'((2 * k) * (2 * k + 1));
      term = -((term * x2) / one) / den;
      acc  = acc + term;
    end
    val = (acc * 64'sd2047 + one / 2) / one;
    return 11'(val);
  endfunction

endpackage

// File: rtl/dds_waveform_gen_lut.sv
// Quarter-wave sine ROM with a registered read port.
// Entries are computed at elaboration, so synthesis sees a constant table.
module dds_sine_quarter_lut
  import dds_pkg::*;
#(
  parameter int LUT_AW = 8
) (
  input  logic              clk_1MHz,
  input  logic [LUT_AW-1:0] addr,
  output logic [10:0]       data
);

  logic [10:0] rom [2**LUT_AW];

  for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
    localparam logic [10:0] ENTRY = sine_quarter(g, LUT_AW);
    assign rom[g] = ENTRY;
  end

  // Synchronous read: data corresponds to the address of the previous cycle.
  always_ff @(posedge clk_1MHz) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/dds_waveform_gen.sv
// Direct digital synthesis core feeding a 12-bit SPI DAC driver.
// One sample per SAMPLE_DIV-cycle frame; sine/triangle/sawtooth/square.
// Optional build macro DDS_AMPLITUDE_SCALE_EN adds an amplitude stage
// (gain in 1/16 steps, saturated) and one cycle of latency.
module dds_waveform_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_DIV = 18,
  parameter int LUT_AW     = 8
) (
  input  logic               clk_1MHz,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [1:0]         wave_sel,
  input  logic [4:0]         amplitude,
  output logic [DAC_W-1:0]   value_out,
  output logic               sample_valid
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [PHASE_W-1:0] phase;
  logic [LUT_AW-1:0]  lut_addr;
  logic [10:0]        lut_q;

  logic               s1_valid;
  logic               s1_en;
  logic [DAC_W-1:0]   s1_p;
  wave_e              s1_wave;
  logic [DAC_W-1:0]   v;

  assign tick = (cnt == CNT_W'(SAMPLE_DIV - 1));

  // Frame pacing counter, free-running regardless of en.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= tick ? '0 : cnt + 1'b1;
  end

  // Odd quadrants read the table mirrored so only a quarter wave is stored.
  assign lut_addr = phase[PHASE_W-2] ? ~phase[PHASE_W-3 -: LUT_AW]
                                     :  phase[PHASE_W-3 -: LUT_AW];

  dds_sine_quarter_lut #(.LUT_AW(LUT_AW)) u_lut (
    .clk_1MHz (clk_1MHz),
    .addr     (lut_addr),
    .data     (lut_q)
  );

  // Phase step and stage-1 capture; the live tuning word at tick sets this frame's step.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      s1_valid <= 1'b0;
      s1_en    <= 1'b0;
      s1_p     <= '0;
      s1_wave  <= WAVE_SINE;
    end else begin
      s1_valid <= tick;
      if (tick) begin
        s1_en   <= en;
        s1_p    <= phase[PHASE_W-1 -: DAC_W];
        s1_wave <= wave_e'(wave_sel);
        phase   <= en ? phase + tuning_word : '0;
      end
    end
  end

  // Waveform shaping from the captured phase word and table output.
  always_comb begin
    v = MIDSCALE;
    if (s1_en) begin
      case (s1_wave)
        WAVE_SINE: v = s1_p[11] ? (12'd2047 - {1'b0, lut_q}) : (MIDSCALE + {1'b0, lut_q});
        WAVE_TRI:  v = s1_p[11] ? (12'd4095 - {s1_p[10:0], 1'b0}) : {s1_p[10:0], 1'b0};
        WAVE_SAW:  v = s1_p;
        WAVE_SQR:  v = s1_p[11] ? 12'd0 : 12'd4095;
        default:   v = MIDSCALE;
      endcase
    end
  end

`ifdef DDS_AMPLITUDE_SCALE_EN
  logic [4:0]         s1_amp;
  logic [4:0]         s2_amp;
  logic [DAC_W-1:0]   s2_v;
  logic               s2_valid;
  logic [4:0]         amp_eff;
  logic signed [12:0] s_off;
  logic signed [18:0] prod;
  logic signed [18:0] shifted;
  logic signed [18:0] sum;
  logic [DAC_W-1:0]   scaled;

  // Amplitude shadow, captured with the other inputs at tick.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst)       s1_amp <= AMP_UNITY;
    else if (tick) s1_amp <= amplitude;
  end

  // Stage 2 holds the raw sample for the gain multiply.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_v     <= MIDSCALE;
      s2_amp   <= AMP_UNITY;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_v   <= v;
        s2_amp <= s1_amp;
      end
    end
  end

  // Gain about midscale, gain capped at unity, result saturated to DAC range.
  always_comb begin
    amp_eff = (s2_amp > AMP_UNITY) ? AMP_UNITY : s2_amp;
    s_off   = $signed({1'b0, s2_v}) - 13'sd2048;
    prod    = s_off * $signed({1'b0, amp_eff});
    shifted = prod >>> 4;
    sum     = shifted + 19'sd2048;
    if (sum < 19'sd0)         scaled = 12'd0;
    else if (sum > 19'sd4095) scaled = 12'd4095;
    else                      scaled = sum[11:0];
  end

  // Output register, updated only on the sample pulse.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      value_out    <= MIDSCALE;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= s2_valid;
      if (s2_valid) value_out <= scaled;
    end
  end
`else
  logic unused_amplitude;
  assign unused_amplitude = ^amplitude;

  // Output register, updated only on the sample pulse.
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      value_out    <= MIDSCALE;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= s1_valid;
      if (s1_valid) value_out <= v;
    end
  end
`endif

endmodule
